gnrc_rr_arb_therm: RTL
======================

Name: gnrc_rr_arb_therm

Overview:
- N-to-1 round-robin arbiter with valid/ready handshake and a data mux.
- Fairness pointer is stored as a thermometer mask, not a binary index.
- Winner selection is two find-first-set passes: masked requests first, then all requests.
- Both passes are computed with the codebase's thermometer leading-zero counter.
- Used in front of any shared single-port resource: bus port, shared FU, write-back port.

Parameters:
- N, 4, number of requesters, range >=1.
- DW, 32, data width per requester, range >=1.
- LOCK, 1, when 1 a presented grant is held until its handshake completes; when 0 arbitration is re-evaluated every cycle.
- IdxW, (N>1 ? $clog2(N) : 1), derived width of idx_o; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of priority pointer and lock.
- req_i  in  N  per-requester valid.
- data_i  in  N*DW  packed per-requester payload; requester i occupies [i*DW +: DW].
- gnt_o  out  N  per-requester ready (one-hot or zero).
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- idx_o  out  IdxW  binary index of the current winner.
- data_o  out  DW  payload of the current winner.

Behaviour:
- Latency: zero. Arbitration is combinational from req_i and registered state to valid_o/idx_o/data_o/gnt_o.
- State: mask_q[N], thermometer form; bit i=1 means requester i is in the preferred (upper) window.
- State: lock_q (1 bit) and lock_idx_q[IdxW], used only when LOCK=1.
- Reset values: mask_q='0, lock_q=0, lock_idx_q=0.
- Outputs with req_i='0: valid_o=0, gnt_o='0, idx_o=0, data_o='0.
- Selection order:
  - If req_i & mask_q is nonzero, winner = lowest set index of (req_i & mask_q).
  - Otherwise winner = lowest set index of req_i.
- Find-first-set from LSB: t = therm(v), where t[i] = ~|v[i:0]. Then onehot = v & {t[N-2:0],1'b1}.
- valid_o = |req_i.
- gnt_o = onehot & {N{ready_i}}.
- data_o = OR-reduction of data_i slices gated by onehot; no X-propagation from unselected slices.
- Pointer update on handshake (valid_o & ready_i) with winner w:
  - mask_q <= bits strictly above w set, i.e. ~therm-style mask of (1<<w) with bit w cleared.
  - If w==N-1, mask_q <= '0 (wrap).
  - No handshake: mask_q holds.
- FSM, when LOCK=1, has two states:
  - ARB (lock_q=0): normal selection. If valid_o & ~ready_i, go to LOCKED and capture lock_idx_q=winner.
  - LOCKED (lock_q=1): the winner is forced to lock_idx_q regardless of other requests or mask.
  - LOCKED on handshake: update pointer from lock_idx_q, return to ARB.
  - LOCKED when req_i[lock_idx_q] deasserts (protocol violation): return to ARB; that same cycle arbitrates normally over the remaining requests with no pointer update from the lock.
- When LOCK=0: lock_q is constant 0 and the FSM is absent.
- flush_i: next state mask_q='0, lock_q=0. Flush has priority over any same-cycle handshake pointer update. Same-cycle outputs are unaffected, since they come from current state.
- Reset mid-transfer: asynchronous clear of all state; outputs follow the req_i='0 / reset-pointer rules immediately.
- N=1: valid_o=req_i[0], gnt_o=ready_i & req_i[0], idx_o=0, mask_q unused (tied 0).
- Assertions:
  - $onehot0(gnt_o).
  - gnt_o implies valid_o & ready_i.
  - With LOCK=1, idx_o stable while valid_o & ~ready_i and the locked request stays high.

Decomposition:
- Package gnrc_arb_pkg holds:
  - function idx_w(N) returning IdxW.
  - typedef enum logic {ARB, LOCKED} arb_state_e.
- Sub-module: reuse the existing gnrc_lzc_therm twice, once for the masked vector and once for the unmasked vector.
- Onehot-to-binary for idx_o is inline logic; no new module.

Test Plan:
- Reset, then req_i=0000, ready_i=1 for 3 cycles -> valid_o=0, gnt_o=0000, idx_o=0, data_o=0.
- N=4, req_i=1111 and ready_i=1 held for 5 cycles -> idx_o sequence 0,1,2,3,0; gnt_o 0001,0010,0100,1000,0001.
- req_i=1010, ready_i=1 for 4 cycles -> idx_o 1,3,1,3. Wrap after 3 leaves mask_q=0000.
- LOCK=1 lock hold:
  - Stimulus: req_i=0110, ready_i=0 for 3 cycles; req_i[0] also asserted at cycle 2.
  - Required: idx_o=1 throughout and gnt_o=0000.
  - Then ready_i=1 -> gnt_o=0010; next cycle with req_i=0111, idx_o=2.
- Handshake winner 2, then flush_i=1 for one cycle, then req_i=1111, ready_i=1 -> idx_o=0, not 3.
- Locked on requester 3, then drop req_i[3] with req_i=0001 -> same cycle valid_o=1, idx_o=0, FSM returns to ARB. Separately, rst_ni pulsed low while LOCKED -> mask_q=0, lock_q=0 asynchronously.

Source files
------------

// File: rtl/gnrc_arb_pkg.sv
// Shared types and helpers for the generic arbiter family.
package gnrc_arb_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {ARB, LOCKED} arb_state_e;

endpackage

// File: rtl/gnrc_lzc_therm.sv
// Thermometer-based find-first-set: therm[i] is high while no bit of vec[i:0] is set,
// so the first set bit is the only position where vec is high and therm below it is still high.
module gnrc_lzc_therm #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic         empty
);

  logic [N-1:0] therm;

  always_comb begin
    therm    = '0;
    therm[0] = ~vec[0];
    for (int i = 1; i < N; i++) begin
      therm[i] = therm[i-1] & ~vec[i];
    end
  end

  if (N == 1) begin : g_single
    assign onehot = vec;
  end else begin : g_multi
    assign onehot = vec & {therm[N-2:0], 1'b1};
  end

  assign empty = therm[N-1];

endmodule

// File: rtl/gnrc_rr_arb_therm.sv
// Round-robin N:1 arbiter with valid/ready handshake; the fairness pointer is kept as a
// thermometer mask of requesters strictly above the last winner.
module gnrc_rr_arb_therm
  import gnrc_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter bit LOCK = 1'b1,
  parameter int IdxW = idx_w(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [N-1:0]      req_i,
  input  logic [N*DW-1:0]   data_i,
  output logic [N-1:0]      gnt_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IdxW-1:0]   idx_o,
  output logic [DW-1:0]     data_o
);

  logic [N-1:0]    mask_q;
  logic [N-1:0]    mask_d;
  logic [N-1:0]    req_masked;
  logic [N-1:0]    masked_oh;
  logic [N-1:0]    req_oh;
  logic [N-1:0]    arb_oh;
  logic [N-1:0]    lock_oh;
  logic [N-1:0]    win_oh;
  logic            masked_empty;
  logic            req_empty;
  logic            lock_q;
  logic            lock_hit;
  logic [IdxW-1:0] lock_idx_q;
  logic            handshake;

  assign req_masked = req_i & mask_q;

  gnrc_lzc_therm #(.N(N)) u_lzc_masked (
    .vec    (req_masked),
    .onehot (masked_oh),
    .empty  (masked_empty)
  );

  gnrc_lzc_therm #(.N(N)) u_lzc_all (
    .vec    (req_i),
    .onehot (req_oh),
    .empty  (req_empty)
  );

  always_comb begin
    lock_oh = '0;
    for (int i = 0; i < N; i++) begin
      lock_oh[i] = (lock_idx_q == IdxW'(i));
    end
  end

  // A lock only pins the winner while its request is still up; otherwise plain arbitration.
  assign lock_hit  = lock_q & |(req_i & lock_oh);
  assign arb_oh    = masked_empty ? req_oh : masked_oh;
  assign win_oh    = lock_hit ? lock_oh : arb_oh;

  assign valid_o   = ~req_empty;
  assign gnt_o     = win_oh & {N{ready_i}};
  assign handshake = valid_o & ready_i;

  always_comb begin
    idx_o  = '0;
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      idx_o  = idx_o | (win_oh[i] ? IdxW'(i) : '0);
      data_o = data_o | (data_i[i*DW +: DW] & {DW{win_oh[i]}});
    end
  end

  // Prefix-OR of the winner one-hot yields the bits strictly above it; winner N-1 wraps to zero.
  always_comb begin
    mask_d = mask_q;
    if (handshake) begin
      mask_d = '0;
      for (int i = 1; i < N; i++) begin
        mask_d[i] = mask_d[i-1] | win_oh[i-1];
      end
    end
    if (flush_i) begin
      mask_d = '0;
    end
  end

  if (N > 1) begin : g_mask
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mask_q <= '0;
      end else begin
        mask_q <= mask_d;
      end
    end
  end else begin : g_no_mask
    assign mask_q = '0;
  end

  if (LOCK) begin : g_lock
    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [IdxW-1:0] lock_idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q    <= ARB;
        lock_idx_q <= '0;
      end else begin
        state_q    <= state_d;
        lock_idx_q <= lock_idx_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      unique case (state_q)
        ARB: begin
          if (valid_o && !ready_i) begin
            state_d    = LOCKED;
            lock_idx_d = idx_o;
          end
        end
        LOCKED: begin
          if (!lock_hit || ready_i) begin
            state_d = ARB;
          end
        end
      endcase
      if (flush_i) begin
        state_d = ARB;
      end
    end

    assign lock_q = (state_q == LOCKED);

    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !flush_i) |=> (!lock_hit || $stable(idx_o)));
  end else begin : g_no_lock
    assign lock_q     = 1'b0;
    assign lock_idx_q = '0;
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));

  a_gnt_handshake: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|gnt_o) |-> (valid_o && ready_i));

endmodule
